// File: rtl/pla_preimage_search.sv
// Purpose : sweeps every input vector of an external combinational PLA and
//           reports which candidates drive it to a masked target output word.
// Ports   : clk/rst; start_i, first_only_i, abort_i control; target_i/care_i
//           are latched at start; cand_o goes to the PLA and dut_out_i comes
//           back from it; busy_o, done_o, found_o, result_o, match_cnt_o report.
// Latency : each candidate takes LAT+1 cycles. done_o pulses 2^IN_W*(LAT+1)+1
//           edges after the start edge, or (m+1)*(LAT+1)+1 edges when
//           first-only mode stops at its first match m.
// Backpr. : none. start_i is taken only in IDLE. abort_i acts only in SETTLE.
module pla_preimage_search #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 7,
   parameter int LAT   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              first_only_i,
   input  logic              abort_i,
   input  logic [OUT_W-1:0]  target_i,
   input  logic [OUT_W-1:0]  care_i,
   output logic [IN_W-1:0]   cand_o,
   input  logic [OUT_W-1:0]  dut_out_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              found_o,
   output logic [IN_W-1:0]   result_o,
   output logic [IN_W:0]     match_cnt_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Settle count reloaded for every candidate. LAT is limited to 0..15.
   localparam logic [3:0] LAT_V = 4'(LAT);

   state_t              state;
   logic [3:0]          wcnt;
   logic [OUT_W-1:0]    tgt_q;
   logic [OUT_W-1:0]    care_q;
   logic                first_only_q;
   logic                hit;
   logic                last_cand;

   // The PLA is combinational, so its response to cand_o is already valid in
   // the same cycle. Bits with a 0 in the care mask are ignored.
   assign hit       = ((dut_out_i ^ tgt_q) & care_q) == '0;
   assign last_cand = (cand_o == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wcnt         <= '0;
         tgt_q        <= '0;
         care_q       <= '0;
         first_only_q <= 1'b0;
         cand_o       <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         found_o      <= 1'b0;
         result_o     <= '0;
         match_cnt_o  <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  tgt_q        <= target_i;
                  care_q       <= care_i;
                  first_only_q <= first_only_i;
                  cand_o       <= '0;
                  wcnt         <= LAT_V;
                  found_o      <= 1'b0;
                  result_o     <= '0;
                  match_cnt_o  <= '0;
                  busy_o       <= 1'b1;
                  state        <= SETTLE;
               end
            end

            SETTLE: begin
               if (abort_i) begin
                  // The results keep their partial values. No done_o pulse
                  // follows, so the caller knows the sweep did not finish.
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end else if (wcnt != 4'd0) begin
                  wcnt <= wcnt - 4'd1;
               end else begin
                  if (hit) begin
                     // IN_W+1 bits can hold 2^IN_W, so the count cannot wrap.
                     match_cnt_o <= match_cnt_o + (IN_W+1)'(1);
                     if (!found_o) begin
                        found_o  <= 1'b1;
                        result_o <= cand_o;
                     end
                  end
                  // The all-ones candidate ends the sweep. The counter never
                  // wraps, so cand_o holds that value after the sweep.
                  if ((first_only_q && hit) || last_cand) begin
                     busy_o <= 1'b0;
                     state  <= DONE;
                  end else begin
                     cand_o <= cand_o + IN_W'(1);
                     wcnt   <= LAT_V;
                  end
               end
            end

            DONE: begin
               // start_i is ignored here. done_o is high for the single cycle
               // after this edge, and the FSM is back in IDLE by then.
               done_o <= 1'b1;
               state  <= IDLE;
            end

            default: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pla_preimage_search.sv
// Purpose : drives two search engines (LAT=0 and LAT=2) from one stimulus
//           stream. Each engine sweeps a modelled PLA, and a monitor checks
//           each done_o pulse against queued reference results.
// Ports   : none. This is the top-level testbench.
module tb_pla_preimage_search;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start, first_only, abort, force6;
   logic [6:0] target, care;

   logic [7:0] cand   [2];
   logic [6:0] dout   [2];
   logic       busy   [2];
   logic       done   [2];
   logic       found  [2];
   logic [7:0] result [2];
   logic [8:0] mcnt   [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Modelled PLA. force6 clears output bit 6, which leaves target 0x40
   // without a preimage.
   function automatic logic [6:0] pla(input logic [7:0] v, input logic f6);
      logic [6:0] r;
      r = v[6:0] ^ {7{v[7]}};
      if (f6) r[6] = 1'b0;
      return r;
   endfunction

   assign dout[0] = pla(cand[0], force6);
   assign dout[1] = pla(cand[1], force6);

   pla_preimage_search #(.IN_W(8), .OUT_W(7), .LAT(0)) u_lat0 (
      .clk(clk), .rst(rst), .start_i(start), .first_only_i(first_only),
      .abort_i(abort), .target_i(target), .care_i(care), .cand_o(cand[0]),
      .dut_out_i(dout[0]), .busy_o(busy[0]), .done_o(done[0]),
      .found_o(found[0]), .result_o(result[0]), .match_cnt_o(mcnt[0]));

   pla_preimage_search #(.IN_W(8), .OUT_W(7), .LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .start_i(start), .first_only_i(first_only),
      .abort_i(abort), .target_i(target), .care_i(care), .cand_o(cand[1]),
      .dut_out_i(dout[1]), .busy_o(busy[1]), .done_o(done[1]),
      .found_o(found[1]), .result_o(result[1]), .match_cnt_o(mcnt[1]));

   typedef struct {
      logic       found;
      logic [7:0] result;
      logic [8:0] cnt;
      int         start_edge;
      int         lat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model. It walks the candidates below limit in order and
   // applies the match rule directly.
   task automatic model(input bit fo, input logic [6:0] t, input logic [6:0] c,
                        input bit f6, input int lat, input int limit, output exp_t e);
      bit stop;
      logic [6:0] o;
      stop     = 0;
      e.found  = 1'b0;
      e.result = '0;
      e.cnt    = '0;
      e.start_edge = 0;
      e.lat    = 256 * (lat + 1) + 1;
      for (int v = 0; v < limit; v++) begin
         if (!stop) begin
            o = pla(8'(v), f6);
            if (((o ^ t) & c) == 7'd0) begin
               e.cnt = e.cnt + 9'd1;
               if (!e.found) begin
                  e.found  = 1'b1;
                  e.result = 8'(v);
               end
               if (fo) begin
                  stop  = 1;
                  e.lat = (v + 1) * (lat + 1) + 1;
               end
            end
         end
      end
   endtask

   // Monitor. It pops one expectation per done_o pulse and checks that each
   // candidate is held for LAT+1 cycles.
   logic [7:0] prev_cand [2];
   logic       prev_busy [2];
   int         run_len   [2];

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            prev_busy[i] = 1'b0;
            run_len[i]   = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  check($sformatf("done_unexpected[%0d]", i), 32'(done[i]), 32'd0);
               end else begin
                  if (i == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  check($sformatf("found[%0d]", i),   32'(found[i]),  32'(e.found));
                  check($sformatf("result[%0d]", i),  32'(result[i]), 32'(e.result));
                  check($sformatf("match_cnt[%0d]", i), 32'(mcnt[i]), 32'(e.cnt));
                  check($sformatf("done_latency[%0d]", i), 32'(cyc - e.start_edge), 32'(e.lat));
               end
            end
            if (busy[i]) begin
               if (prev_busy[i] && cand[i] != prev_cand[i]) begin
                  check($sformatf("cand_hold[%0d]", i), 32'(run_len[i]), 32'(i == 0 ? 1 : 3));
                  run_len[i] = 1;
               end else if (prev_busy[i]) begin
                  run_len[i] = run_len[i] + 1;
               end else begin
                  run_len[i] = 1;
               end
            end
            prev_busy[i] = busy[i];
            prev_cand[i] = cand[i];
         end
      end
   end

   task automatic go(input bit fo, input logic [6:0] t, input logic [6:0] c,
                     input bit f6, input bit expect_done);
      exp_t e;
      @(posedge clk); #1;
      first_only = fo; target = t; care = c; force6 = f6; start = 1'b1;
      if (expect_done) begin
         model(fo, t, c, f6, 0, 256, e); e.start_edge = cyc + 1; q0.push_back(e);
         model(fo, t, c, f6, 2, 256, e); e.start_edge = cyc + 1; q1.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      // The engines latch these at start, so scrambling them now must not matter.
      target = 7'($urandom); care = 7'($urandom); first_only = 1'($urandom);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while ((q0.size() != 0 || q1.size() != 0) && k < 1200) begin
         @(negedge clk);
         k++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         total++; bad++;
         $display("FAIL done_timeout pending=%0d/%0d required=0/0", q0.size(), q1.size());
         q0.delete(); q1.delete();
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_cand[%0d]", tag, i),   32'(cand[i]),   32'd0);
         check($sformatf("%s_busy[%0d]", tag, i),   32'(busy[i]),   32'd0);
         check($sformatf("%s_done[%0d]", tag, i),   32'(done[i]),   32'd0);
         check($sformatf("%s_found[%0d]", tag, i),  32'(found[i]),  32'd0);
         check($sformatf("%s_result[%0d]", tag, i), 32'(result[i]), 32'd0);
         check($sformatf("%s_mcnt[%0d]", tag, i),   32'(mcnt[i]),   32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   k;
      logic [7:0] cand1_at;
      rst = 1'b1; start = 1'b0; first_only = 1'b0; abort = 1'b0; force6 = 1'b0;
      target = '0; care = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("idle");

      // Full sweep: matches at 0x05 and 0xFA.
      go(1'b0, 7'h05, 7'h7F, 1'b0, 1'b1); wait_done();
      // First-only mode: stops at 0x05.
      go(1'b1, 7'h05, 7'h7F, 1'b0, 1'b1); wait_done();
      // Empty care mask: every candidate matches.
      go(1'b0, 7'h2A, 7'h00, 1'b0, 1'b1); wait_done();
      // Target with no preimage.
      go(1'b0, 7'h40, 7'h7F, 1'b1, 1'b1); wait_done();
      go(1'b1, 7'h40, 7'h7F, 1'b1, 1'b1); wait_done();

      // Abort at cand 0x30 in the LAT=0 engine. No done_o follows and the
      // partial results are kept.
      go(1'b0, 7'h05, 7'h7F, 1'b0, 1'b0);
      k = 0;
      while (cand[0] != 8'h30 && k < 100) begin @(negedge clk); k++; end
      check("abort_reach_0x30", 32'(cand[0]), 32'h30);
      cand1_at = cand[1];
      abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      model(1'b0, 7'h05, 7'h7F, 1'b0, 0, 8'h30, e);
      check("abort_busy[0]", 32'(busy[0]), 32'd0);
      check("abort_found[0]", 32'(found[0]), 32'(e.found));
      check("abort_cnt[0]", 32'(mcnt[0]), 32'(e.cnt));
      model(1'b0, 7'h05, 7'h7F, 1'b0, 2, int'(cand1_at), e);
      check("abort_busy[1]", 32'(busy[1]), 32'd0);
      check("abort_cnt[1]", 32'(mcnt[1]), 32'(e.cnt));
      repeat (10) @(negedge clk);
      go(1'b0, 7'h33, 7'h7E, 1'b0, 1'b1); wait_done();

      // A start pulse during a sweep must be ignored.
      go(1'b0, 7'h7A, 7'h7F, 1'b0, 1'b1);
      repeat (20) @(posedge clk);
      #1; start = 1'b1; target = 7'h11; care = 7'h7F; first_only = 1'b1;
      repeat (3) @(posedge clk);
      #1; start = 1'b0;
      wait_done();

      // Random runs.
      for (int n = 0; n < 8; n++) begin
         logic [6:0] c;
         c = (n == 3) ? 7'h00 : 7'($urandom);
         go(1'($urandom), 7'($urandom), c, 1'($urandom), 1'b1);
         wait_done();
      end

      // Asynchronous reset between clock edges, in the middle of a sweep.
      go(1'b0, 7'h05, 7'h7F, 1'b0, 1'b0);
      repeat (40) @(posedge clk);
      #3; rst = 1'b1;
      #1; check_all_zero("async_rst");
      @(negedge clk); rst = 1'b0;
      repeat (20) @(negedge clk);
      check_all_zero("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
